lsu_axi_master: RTL

- Parametrised load/store unit: the next generation of the write-back-stage memory sequencer.
- Accepts one load or store request at a time from the execute/write-back path.
- Drives independent AXI4-Lite read (AR/R) and write (AW/W/B) channels.
- Returns a single-cycle response with size-extracted, sign/zero-extended load data and an error code.
- Adds misalignment detection, byte-lane steering, bus-error reporting and a configurable bus width.

---
 rtl/lsu_axi_master.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_axi_master.sv
// Load/store sequencer: one request at a time onto AXI4-Lite read and write channels,
// with misalignment detection, byte-lane steering and sign/zero extension of load data.
module lsu_axi_master #(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [1:0]        resp_err,
    output logic              mem_arvalid,
    input  logic              mem_arready,
    output logic [ADDR_W-1:0] mem_araddr,
    input  logic              mem_rvalid,
    output logic              mem_rready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [1:0]        mem_rresp,
    output logic              mem_awvalid,
    input  logic              mem_awready,
    output logic [ADDR_W-1:0] mem_awaddr,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_bvalid,
    output logic              mem_bready,
    input  logic [1:0]        mem_bresp
);

    // state   | meaning
    // IDLE    | waiting for a request, req_ready high
    // RD_ADDR | AR valid, waiting for arready
    // RD_DATA | R ready, waiting for rvalid
    // WR_REQ  | AW and W valid, each dropping after its own handshake
    // WR_RESP | B ready, waiting for bvalid
    // DONE    | one-cycle response pulse
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam int OFF_W = $clog2(STRB_W);

    logic [2:0]        state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        err_q, err_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;

    logic [OFF_W-1:0]  req_off;
    logic              req_misal;
    logic [STRB_W-1:0] strb_base;
    logic [DATA_W-1:0] req_wdata_al;
    logic [STRB_W-1:0] req_wstrb_al;

    logic [OFF_W-1:0]  rd_off;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] rd_mask;
    logic              rd_sign;
    logic [DATA_W-1:0] rd_ext;

    assign req_off = req_addr[OFF_W-1:0];

    always_comb begin
        req_misal = 1'b0;
        strb_base = '0;
        case (req_size)
            2'd0: begin
                req_misal = 1'b0;
                strb_base = STRB_W'(1'b1);
            end
            2'd1: begin
                req_misal = req_addr[0];
                strb_base = STRB_W'(2'b11);
            end
            2'd2: begin
                req_misal = |req_addr[1:0];
                strb_base = STRB_W'(4'hF);
            end
            default: begin
                // dword only exists on a 64-bit bus
                req_misal = (DATA_W == 32) || (|req_addr[2:0]);
                strb_base = '1;
            end
        endcase
        req_wdata_al = req_wdata << {req_off, 3'b000};
        req_wstrb_al = strb_base << req_off;
    end

    assign rd_off   = addr_q[OFF_W-1:0];
    assign rd_shift = mem_rdata >> {rd_off, 3'b000};

    always_comb begin
        rd_mask = '1;
        rd_sign = 1'b0;
        case (size_q)
            2'd0: begin
                rd_mask = DATA_W'(8'hFF);
                rd_sign = rd_shift[7];
            end
            2'd1: begin
                rd_mask = DATA_W'(16'hFFFF);
                rd_sign = rd_shift[15];
            end
            2'd2: begin
                rd_mask = DATA_W'(32'hFFFF_FFFF);
                rd_sign = rd_shift[31];
            end
            default: begin
                rd_mask = '1;
                rd_sign = rd_shift[DATA_W-1];
            end
        endcase
        rd_ext = (rd_shift & rd_mask) | ((rd_sign && !uns_q) ? ~rd_mask : '0);
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        uns_d     = uns_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d    = req_addr;
                    size_d    = req_size;
                    uns_d     = req_unsigned;
                    wdata_d   = req_wdata_al;
                    wstrb_d   = req_wstrb_al;
                    rdata_d   = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (req_misal) begin
                        err_d   = 2'b01;
                        state_d = DONE;
                    end else begin
                        err_d   = 2'b00;
                        state_d = req_we ? WR_REQ : RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (mem_arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (mem_rvalid) begin
                    if (mem_rresp != 2'b00) begin
                        err_d   = 2'b10;
                        rdata_d = '0;
                    end else begin
                        rdata_d = rd_ext;
                    end
                    state_d = DONE;
                end
            end
            WR_REQ: begin
                // move on only once both handshakes are already recorded
                if (aw_done_q && w_done_q) begin
                    state_d = WR_RESP;
                end else begin
                    if (mem_awready && !aw_done_q) aw_done_d = 1'b1;
                    if (mem_wready && !w_done_q) w_done_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (mem_bvalid) begin
                    if (mem_bresp != 2'b00) err_d = 2'b10;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d   = IDLE;
                addr_d    = '0;
                size_d    = '0;
                uns_d     = 1'b0;
                wdata_d   = '0;
                wstrb_d   = '0;
                rdata_d   = '0;
                err_d     = 2'b00;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 2'b00;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = (state_q == DONE);
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;
    assign mem_arvalid = (state_q == RD_ADDR);
    assign mem_rready  = (state_q == RD_DATA);
    assign mem_araddr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign mem_awaddr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign mem_awvalid = (state_q == WR_REQ) && !aw_done_q;
    assign mem_wvalid  = (state_q == WR_REQ) && !w_done_q;
    assign mem_wdata   = wdata_q;
    assign mem_wstrb   = wstrb_q;
    assign mem_bready  = (state_q == WR_RESP);

endmodule
